// File: rtl/kolibri_bus_pkg.sv
// Shared Kolibri bus definitions: wait-stretch FSM states and default stretch limits.
package kolibri_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStretch,
      StHold,
      StRelease
   } wait_state_e;

   localparam int unsigned MIN_WAIT_DEF = 24;
   localparam int unsigned TIMEOUT_DEF  = 480;
   localparam int unsigned MIN_CNT_W    = 8;
   localparam int unsigned TO_CNT_W     = 10;

endpackage

// File: rtl/edge_sync.sv
// Registers one input once and reports rise/fall of the registered copy against a
// one-cycle-delayed copy. Both flops reset high, matching the idle level of the bus strobes.
module edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic q_q, q_d;
   logic dly_q, dly_d;

   always_comb begin
      q_d   = d_i;
      dly_d = q_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q   <= 1'b1;
         dly_q <= 1'b1;
      end else begin
         q_q   <= q_d;
         dly_q <= dly_d;
      end
   end

   assign q_o    = q_q;
   assign rise_o = q_q & ~dly_q;
   assign fall_o = ~q_q & dly_q;

endmodule

// File: rtl/wait_gen.sv
// V9958 access wait generator: stretches the 6309 E phase via nWAIT until the VDP is ready.
// Define WAIT_TIMEOUT_EN to add the forced-release timeout counter and sticky TIMEOUT_FLAG.
module wait_gen
   import kolibri_bus_pkg::*;
#(
   parameter int unsigned MIN_WAIT = MIN_WAIT_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
   input  logic MHZ48,
   input  logic nRESET,
   input  logic nE,
   input  logic nVDPCS,
   input  logic nVDPRDY,
   output logic nWAIT,
   output logic BUSY,
   output logic TIMEOUT_FLAG,
   input  logic TO_CLR
);

   localparam logic [MIN_CNT_W-1:0] MinLoad = MIN_CNT_W'(MIN_WAIT - 1);

   logic ne_q, e_rise, e_fall;
   logic cs_q, cs_rise, cs_fall;
   logic rdy_q, rdy_rise, rdy_fall;

   edge_sync u_sync_ne (
      .clk_i  (MHZ48),
      .rst_ni (nRESET),
      .d_i    (nE),
      .q_o    (ne_q),
      .rise_o (e_rise),
      .fall_o (e_fall)
   );

   edge_sync u_sync_cs (
      .clk_i  (MHZ48),
      .rst_ni (nRESET),
      .d_i    (nVDPCS),
      .q_o    (cs_q),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   edge_sync u_sync_rdy (
      .clk_i  (MHZ48),
      .rst_ni (nRESET),
      .d_i    (nVDPRDY),
      .q_o    (rdy_q),
      .rise_o (rdy_rise),
      .fall_o (rdy_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{ne_q, cs_rise, cs_fall, rdy_rise, rdy_fall};

   wait_state_e          state_q, state_d;
   logic [MIN_CNT_W-1:0] min_q, min_d, min_dec;
   logic                 nwait_q, nwait_d;
   logic                 busy_q, busy_d;
   logic                 to_load, to_run, to_set, to_expired;

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      nwait_d = nwait_q;
      busy_d  = busy_q;
      to_load = 1'b0;
      to_run  = 1'b0;
      to_set  = 1'b0;
      min_dec = (min_q == '0) ? '0 : min_q - MIN_CNT_W'(1);

      case (state_q)
         StIdle: begin
            if (e_fall && !cs_q) begin
               state_d = StStretch;
               min_d   = MinLoad;
               to_load = 1'b1;
               nwait_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         StStretch: begin
            min_d  = min_dec;
            to_run = 1'b1;
            // An E rise here means the CPU ended the cycle without us: abort.
            if (e_rise) begin
               state_d = StIdle;
               nwait_d = 1'b1;
               busy_d  = 1'b0;
            end else if (min_dec == '0) begin
               state_d = StHold;
            end
         end
         StHold: begin
            to_run = 1'b1;
            if (e_rise) begin
               state_d = StIdle;
               nwait_d = 1'b1;
               busy_d  = 1'b0;
            end else if (rdy_q) begin
               state_d = StRelease;
               nwait_d = 1'b1;
            end else if (to_expired) begin
               state_d = StRelease;
               nwait_d = 1'b1;
               to_set  = 1'b1;
            end
         end
         StRelease: begin
            if (e_rise) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge MHZ48 or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= StIdle;
         min_q   <= '0;
         nwait_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         nwait_q <= nwait_d;
         busy_q  <= busy_d;
      end
   end

   assign nWAIT = nwait_q;
   assign BUSY  = busy_q;

`ifdef WAIT_TIMEOUT_EN
   logic [TO_CNT_W-1:0] to_q, to_d;
   logic                flag_q, flag_d;

   always_comb begin
      to_d = to_q;
      if (to_load) begin
         to_d = TO_CNT_W'(TIMEOUT - 1);
      end else if (to_run && (to_q != '0)) begin
         to_d = to_q - TO_CNT_W'(1);
      end
      // A set on the same edge as a clear wins.
      flag_d = to_set ? 1'b1 : (TO_CLR ? 1'b0 : flag_q);
   end

   always_ff @(posedge MHZ48 or negedge nRESET) begin
      if (!nRESET) begin
         to_q   <= '0;
         flag_q <= 1'b0;
      end else begin
         to_q   <= to_d;
         flag_q <= flag_d;
      end
   end

   assign to_expired   = (to_q == '0);
   assign TIMEOUT_FLAG = flag_q;
`else
   logic unused_to;
   assign unused_to    = ^{TO_CLR, to_load, to_run, to_set};
   assign to_expired   = 1'b0;
   assign TIMEOUT_FLAG = 1'b0;
`endif

endmodule

// File: tb/tb_wait_gen.sv
// Bench for wait_gen: cycle-level behavioural model compared every cycle, plus literal
// stretch-length and flag expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_wait_gen;

   localparam int unsigned MinWait = 24;
   localparam int unsigned Timeout = 480;
`ifdef WAIT_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic MHZ48   = 1'b0;
   logic nRESET  = 1'b0;
   logic nE      = 1'b1;
   logic nVDPCS  = 1'b1;
   logic nVDPRDY = 1'b1;
   logic TO_CLR  = 1'b0;
   logic nWAIT, BUSY, TIMEOUT_FLAG;

   int errors = 0;
   int checks = 0;

   always #10 MHZ48 = ~MHZ48;

   wait_gen #(
      .MIN_WAIT (MinWait),
      .TIMEOUT  (Timeout)
   ) dut (
      .MHZ48        (MHZ48),
      .nRESET       (nRESET),
      .nE           (nE),
      .nVDPCS       (nVDPCS),
      .nVDPRDY      (nVDPRDY),
      .nWAIT        (nWAIT),
      .BUSY         (BUSY),
      .TIMEOUT_FLAG (TIMEOUT_FLAG),
      .TO_CLR       (TO_CLR)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: inputs seen through one register stage; k counts edges since nWAIT fell.
   bit m_ne_r, m_ne_rr, m_cs_r, m_rdy_r;
   bit m_busy, m_wait, m_flag;
   int m_k;

   always @(posedge MHZ48 or negedge nRESET) begin
      if (!nRESET) begin
         m_ne_r = 1; m_ne_rr = 1; m_cs_r = 1; m_rdy_r = 1;
         m_busy = 0; m_wait = 0; m_flag = 0; m_k = 0;
      end else begin
         bit ev_fall, ev_rise, ev_set;
         ev_fall = m_ne_rr && !m_ne_r;
         ev_rise = !m_ne_rr && m_ne_r;
         ev_set  = 0;
         if (!m_busy) begin
            if (ev_fall && !m_cs_r) begin
               m_busy = 1; m_wait = 1; m_k = 0;
            end
         end else if (m_wait) begin
            m_k++;
            if (ev_rise) begin
               m_busy = 0; m_wait = 0;
            end else if (m_k >= MinWait && m_rdy_r) begin
               m_wait = 0;
            end else if (ToEn && m_k >= Timeout) begin
               m_wait = 0; ev_set = 1;
            end
         end else if (ev_rise) begin
            m_busy = 0;
         end
         if (ev_set) m_flag = 1;
         else if (ToEn && TO_CLR) m_flag = 0;
         m_ne_rr = m_ne_r;
         m_ne_r  = nE;
         m_cs_r  = nVDPCS;
         m_rdy_r = nVDPRDY;
      end
   end

   always @(negedge MHZ48) begin
      if (nRESET) begin
         chk("model_nWAIT", nWAIT, !m_wait);
         chk("model_BUSY", BUSY, m_busy);
         chk("model_FLAG", TIMEOUT_FLAG, m_flag);
      end
   end

   // Length of the most recent nWAIT low pulse, in cycles.
   int low_cnt  = 0;
   int last_low = 0;
   always @(negedge MHZ48) begin
      if (nWAIT === 1'b0) low_cnt++;
      else begin
         if (low_cnt != 0) last_low = low_cnt;
         low_cnt = 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge MHZ48);
      #1;
   endtask

   initial begin
      cyc(3);
      chk("reset_nWAIT", nWAIT, 1'b1);
      chk("reset_BUSY", BUSY, 1'b0);
      chk("reset_FLAG", TIMEOUT_FLAG, 1'b0);
      nRESET = 1'b1;
      cyc(3);

      // Selected, VDP ready: minimum stretch.
      last_low = 0; nVDPCS = 1'b0; nE = 1'b0;
      cyc(40);
      chk_int("min_stretch_len", last_low, 24);
      chk("busy_in_release", BUSY, 1'b1);
      nE = 1'b1; nVDPCS = 1'b1;
      cyc(1);
      chk("busy_before_rise_seen", BUSY, 1'b1);
      cyc(1);
      chk("busy_after_rise", BUSY, 1'b0);
      cyc(5);

      // Unselected E phase.
      last_low = 0; nE = 1'b0;
      cyc(30);
      chk_int("unselected_low", last_low + low_cnt, 0);
      chk("unselected_busy", BUSY, 1'b0);
      nE = 1'b1;
      cyc(5);

      // VDP not ready for 100 cycles.
      last_low = 0; nVDPCS = 1'b0; nVDPRDY = 1'b0; nE = 1'b0;
      cyc(100);
      nVDPRDY = 1'b1; nVDPCS = 1'b1;
      cyc(2);
      chk("rdy_release_nWAIT", nWAIT, 1'b1);
      chk_int("rdy_stretch_len", last_low, 100);
      chk("rdy_no_flag", TIMEOUT_FLAG, 1'b0);
      nE = 1'b1;
      cyc(5);

      // VDP stuck not ready.
      last_low = 0; nVDPCS = 1'b0; nVDPRDY = 1'b0; nE = 1'b0;
      cyc(600);
`ifdef WAIT_TIMEOUT_EN
      chk_int("timeout_len", last_low, 480);
      chk("timeout_flag_set", TIMEOUT_FLAG, 1'b1);
      TO_CLR = 1'b1;
      cyc(1);
      TO_CLR = 1'b0;
      chk("timeout_flag_clr", TIMEOUT_FLAG, 1'b0);
`else
      chk("stuck_nWAIT_low", nWAIT, 1'b0);
      chk("stuck_no_flag", TIMEOUT_FLAG, 1'b0);
`endif
      nE = 1'b1; nVDPCS = 1'b1;
      cyc(3);
      nVDPRDY = 1'b1;
      cyc(5);

      // Reset at cycle 10 of a stretch.
      nVDPCS = 1'b0; nE = 1'b0;
      cyc(12);
      nRESET = 1'b0; nE = 1'b1; nVDPCS = 1'b1;
      #1;
      chk("async_reset_nWAIT", nWAIT, 1'b1);
      chk("async_reset_BUSY", BUSY, 1'b0);
      cyc(2);
      nRESET = 1'b1;
      cyc(4);
      last_low = 0; nVDPCS = 1'b0; nE = 1'b0;
      cyc(40);
      chk_int("post_reset_len", last_low, 24);
      nE = 1'b1; nVDPCS = 1'b1;
      cyc(5);

      // Chip select deasserted during STRETCH.
      last_low = 0; nVDPCS = 1'b0; nE = 1'b0;
      cyc(6);
      nVDPCS = 1'b1;
      cyc(40);
      chk_int("cs_toggle_len", last_low, 24);
      nE = 1'b1;
      cyc(5);

      // E rises early while in HOLD.
      last_low = 0; nVDPCS = 1'b0; nVDPRDY = 1'b0; nE = 1'b0;
      cyc(40);
      nE = 1'b1; nVDPCS = 1'b1;
      cyc(2);
      chk("abort_nWAIT", nWAIT, 1'b1);
      chk("abort_BUSY", BUSY, 1'b0);
      chk_int("abort_len", last_low, 40);
      chk("abort_flag", TIMEOUT_FLAG, 1'b0);
      nVDPRDY = 1'b1;
      cyc(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wait_gen.md
WAIT_GEN -- requirements
Module: wait_gen

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 24: minimum stretch in MHZ48 cycles, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 480: maximum stretch in MHZ48 cycles, legal range MIN_WAIT+1..1023.
REQ-003 SHALL have port MHZ48  input  1: master clock; all state on its rising edge.
REQ-004 SHALL have port nRESET  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port nE  input  1: inverted 6309E E phase from the clock generator.
REQ-006 SHALL have port nVDPCS  input  1: active-low V9958 chip select, decoded from the address bus.
REQ-007 SHALL have port nVDPRDY  input  1: V9958 CPU-interface wait pin; low means the VDP is not ready.
REQ-008 SHALL have port nWAIT  output  1: registered, active-low stretch request to the clock generator.
REQ-009 SHALL have port BUSY  output  1: high while a stretch is in progress.
REQ-010 SHALL have port TIMEOUT_FLAG  output  1: sticky; set when a stretch is force-released.
REQ-011 SHALL have port TO_CLR  input  1: synchronous clear of TIMEOUT_FLAG.

Function
REQ-012 SHALL register nE, nVDPCS and nVDPRDY once; all decisions use the registered copies plus a delayed copy of nE.
REQ-013 SHALL use a four-state FSM: IDLE, STRETCH, HOLD, RELEASE.
REQ-014 IDLE: on a registered nE 1->0 edge with registered nVDPCS=0, SHALL enter STRETCH; nWAIT=0 and BUSY=1 take effect on that same clock edge.
REQ-015 On STRETCH entry, SHALL load min counter = MIN_WAIT-1 and timeout counter = TIMEOUT-1; both decrement by one per cycle and saturate at 0.
REQ-016 STRETCH: when the min counter reaches 0, SHALL go to HOLD.
REQ-017 HOLD: with registered nVDPRDY=1, SHALL go to RELEASE and drive nWAIT=1 on that same edge.
REQ-018 HOLD: when the timeout counter reaches 0 while nVDPRDY=0, SHALL go to RELEASE, set TIMEOUT_FLAG and drive nWAIT=1 (REQ-025 gates this).
REQ-019 RELEASE: BUSY stays 1; on a registered nE 0->1 edge, SHALL go to IDLE with BUSY=0.
REQ-020 The stretch is therefore MIN_WAIT cycles minimum and TIMEOUT cycles maximum, measured from nWAIT falling to nWAIT rising.
REQ-021 Once STRETCH is entered, the cycle is committed: nVDPCS changes during STRETCH, HOLD or RELEASE SHALL be ignored.
REQ-022 A registered nE 0->1 edge in STRETCH or HOLD is a protocol violation: SHALL go directly to IDLE with nWAIT=1 and BUSY=0; TIMEOUT_FLAG is unchanged.
REQ-023 TO_CLR=1 on the same edge that sets TIMEOUT_FLAG: the set SHALL win.

Reset
REQ-024 nRESET=0 SHALL asynchronously force the following, including mid-stretch: state=IDLE, nWAIT=1, BUSY=0, TIMEOUT_FLAG=0, both counters=0, input registers=1.

Configuration
REQ-025 Macro WAIT_TIMEOUT_EN: when defined, the timeout counter and TIMEOUT_FLAG logic of REQ-015/018 SHALL be present.
REQ-026 Without WAIT_TIMEOUT_EN: HOLD SHALL wait indefinitely for nVDPRDY=1, TIMEOUT_FLAG SHALL be tied to 0, and TO_CLR SHALL be ignored.

Structure
REQ-027 The FSM state encoding and the MIN_WAIT/TIMEOUT default constants SHALL live in a shared package, kolibri_bus_pkg.
REQ-028 The input registering and nE edge detection SHALL be one sub-module, edge_sync (1-bit sync plus rise/fall pulses), instantiated three times.

Verification
REQ-029 nE falls with nVDPCS=0 and nVDPRDY=1 -> nWAIT low exactly 24 cycles; BUSY falls on the edge after nE rises.
REQ-030 nE falls with nVDPCS=1 -> nWAIT stays 1 and BUSY stays 0 for the whole E phase.
REQ-031 nVDPRDY held low 100 cycles after select -> nWAIT rises within 2 cycles of nVDPRDY rising; total low time about 100 cycles; TIMEOUT_FLAG=0.
REQ-032 With WAIT_TIMEOUT_EN, nVDPRDY stuck low -> nWAIT rises after exactly 480 cycles and TIMEOUT_FLAG=1; TO_CLR pulse -> flag=0; without the macro, nWAIT stays low.
REQ-033 nRESET pulsed low at cycle 10 of a stretch -> nWAIT=1 immediately and state IDLE; the next selected nE fall starts a full 24-cycle stretch.
REQ-034 nVDPCS toggles high during STRETCH -> stretch completes unchanged; a forced nE rise during HOLD -> immediate IDLE with nWAIT=1.
